// File: rtl/pscan_pkg.sv
// Shared types and defaults for the pattern scan controller: FSM state encoding,
// default memory map, counter width and a 4-bit population count helper.
package pscan_pkg;

  localparam int         CNT_W         = 8;
  localparam int         DEF_STR_LEN   = 32;
  localparam logic [7:0] DEF_BASE_ADDR = 8'd0;
  localparam logic [7:0] DEF_PAT_ADDR  = 8'd32;
  localparam logic [7:0] DEF_RES_ADDR  = 8'd33;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_PAT = 3'd1,
    SCAN   = 3'd2,
    WR_CTB = 3'd3,
    WR_CTO = 3'd4,
    WR_CTS = 3'd5,
    DONE   = 3'd6
  } pscan_state_e;

  function automatic logic [2:0] pop4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/pscan_match.sv
// Combinational 5-bit window matcher: counts pattern hits inside the current byte
// and across the boundary with the previous byte (MSB-first bit stream).
module pscan_match
  import pscan_pkg::*;
(
  input  logic [4:0] pat_i,
  input  logic [7:0] cur_i,
  input  logic [7:0] prev_i,
  output logic [2:0] in_cnt_o,
  output logic       any_o,
  output logic [2:0] x_cnt_o
);

  logic [3:0] in_hit;
  logic [3:0] x_hit;

  assign in_hit = {cur_i[7:3] == pat_i, cur_i[6:2] == pat_i,
                   cur_i[5:1] == pat_i, cur_i[4:0] == pat_i};

  // Windows that start in the previous byte and end in the current one.
  assign x_hit  = {{prev_i[3:0], cur_i[7]}   == pat_i,
                   {prev_i[2:0], cur_i[7:6]} == pat_i,
                   {prev_i[1:0], cur_i[7:5]} == pat_i,
                   {prev_i[0],   cur_i[7:4]} == pat_i};

  assign in_cnt_o = pop4(in_hit);
  assign any_o    = |in_hit;
  assign x_cnt_o  = pop4(x_hit);

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Scans a byte string in memory for a 5-bit pattern and writes the hit counts back.
// Define PSCAN_CROSS_EN to also count byte-crossing windows and write the stream count.
module pattern_scan_ctrl
  import pscan_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int         STR_LEN   = DEF_STR_LEN,
  parameter logic [7:0] PAT_ADDR  = DEF_PAT_ADDR,
  parameter logic [7:0] RES_ADDR  = DEF_RES_ADDR
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic [7:0] mem_wdata,
  output logic       mem_we
);

  localparam logic [7:0] LAST_IDX = 8'(STR_LEN - 1);

  pscan_state_e     state_q, state_d;
  logic [4:0]       pat_q;
  logic [7:0]       idx_q;
  logic [CNT_W-1:0] ctb_q, cto_q;
  logic [2:0]       in_cnt;
  logic             any_hit;
  logic [2:0]       x_cnt;

`ifdef PSCAN_CROSS_EN
  logic [7:0]       prev_q;
  logic [CNT_W-1:0] cts_q;

  pscan_match u_match (
    .pat_i    (pat_q),
    .cur_i    (mem_rdata),
    .prev_i   (prev_q),
    .in_cnt_o (in_cnt),
    .any_o    (any_hit),
    .x_cnt_o  (x_cnt)
  );
`else
  logic [2:0] cross_unused;

  pscan_match u_match (
    .pat_i    (pat_q),
    .cur_i    (mem_rdata),
    .prev_i   (8'd0),
    .in_cnt_o (in_cnt),
    .any_o    (any_hit),
    .x_cnt_o  (cross_unused)
  );
  assign x_cnt = 3'd0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory-facing outputs are decoded from state so reset clears them at once.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    done      = 1'b0;
    mem_addr  = 8'd0;
    mem_wdata = 8'd0;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = LD_PAT;
      end
      LD_PAT: begin
        mem_addr = PAT_ADDR;
        state_d  = SCAN;
      end
      SCAN: begin
        mem_addr = BASE_ADDR + idx_q;
        if (idx_q == LAST_IDX) state_d = WR_CTB;
      end
      WR_CTB: begin
        mem_we    = 1'b1;
        mem_addr  = RES_ADDR;
        mem_wdata = ctb_q;
        state_d   = WR_CTO;
      end
      WR_CTO: begin
        mem_we    = 1'b1;
        mem_addr  = RES_ADDR + 8'd1;
        mem_wdata = cto_q;
`ifdef PSCAN_CROSS_EN
        state_d   = WR_CTS;
`else
        state_d   = DONE;
`endif
      end
`ifdef PSCAN_CROSS_EN
      WR_CTS: begin
        mem_we    = 1'b1;
        mem_addr  = RES_ADDR + 8'd2;
        mem_wdata = cts_q;
        state_d   = DONE;
      end
`endif
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_d = LD_PAT;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_q  <= 5'd0;
      idx_q  <= 8'd0;
      ctb_q  <= '0;
      cto_q  <= '0;
`ifdef PSCAN_CROSS_EN
      cts_q  <= '0;
      prev_q <= 8'd0;
`endif
    end else begin
      case (state_q)
        LD_PAT: begin
          pat_q  <= mem_rdata[7:3];
          idx_q  <= 8'd0;
          ctb_q  <= '0;
          cto_q  <= '0;
`ifdef PSCAN_CROSS_EN
          cts_q  <= '0;
          prev_q <= 8'd0;
`endif
        end
        SCAN: begin
          idx_q <= idx_q + 8'd1;
          ctb_q <= ctb_q + CNT_W'(in_cnt);
          if (any_hit) cto_q <= cto_q + CNT_W'(1);
`ifdef PSCAN_CROSS_EN
          // The first byte has no predecessor, so its crossing windows do not exist.
          cts_q  <= cts_q + CNT_W'(in_cnt) + ((idx_q != 8'd0) ? CNT_W'(x_cnt) : '0);
          prev_q <= mem_rdata;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: behavioural memory, write scoreboard,
// reset-during-scan and start-while-busy cases. Honours PSCAN_CROSS_EN.
module tb_pattern_scan_ctrl;

`ifdef PSCAN_CROSS_EN
  localparam int LAT = 36;
  localparam int NW  = 3;
`else
  localparam int LAT = 35;
  localparam int NW  = 2;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       busy, done, mem_we;
  logic [7:0] mem_addr, mem_rdata, mem_wdata;

  logic [7:0] str_mem [0:31];
  logic [7:0] pat_byte;
  logic [7:0] res_mem [0:2];
  logic [7:0] res_idx;
  logic       clr_res;
  int         wr_cnt = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_addr_q[$];

  always #5 clk = ~clk;

  pattern_scan_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we)
  );

  assign mem_rdata = (mem_addr < 8'd32)  ? str_mem[mem_addr[4:0]] :
                     (mem_addr == 8'd32) ? pat_byte : 8'h00;
  assign res_idx   = mem_addr - 8'd33;

  always @(posedge clk) begin
    if (clr_res) begin
      for (int i = 0; i < 3; i++) res_mem[i] <= 8'hA5;
    end else if (mem_we && mem_addr >= 8'd33 && mem_addr <= 8'd35) begin
      res_mem[res_idx[1:0]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // Scoreboard: every write must match the next expected address/data pair.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected_addr", {24'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        check("wr_addr", mem_addr, exp_addr_q.pop_front());
        check("wr_data", mem_wdata, exp_q.pop_front());
      end
    end
  end

  task automatic load(input logic [7:0] first, input logic [7:0] rest, input logic [7:0] pat);
    str_mem[0] = first;
    for (int i = 1; i < 32; i++) str_mem[i] = rest;
    pat_byte = pat;
  endtask

  task automatic run_scan(input string name, input logic [7:0] e_ctb, input logic [7:0] e_cto,
                          input logic [7:0] e_cts, input bit poke);
    int cyc;
    int w0;
    exp_q.push_back(e_ctb);  exp_addr_q.push_back(8'd33);
    exp_q.push_back(e_cto);  exp_addr_q.push_back(8'd34);
`ifdef PSCAN_CROSS_EN
    exp_q.push_back(e_cts);  exp_addr_q.push_back(8'd35);
`endif
    @(negedge clk); clr_res = 1'b1;
    @(negedge clk); clr_res = 1'b0;
    w0 = wr_cnt;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) check({name, "_done_clr"}, done, 1'b0);
      if (cyc == 10) check({name, "_busy"}, busy, 1'b1);
      if (poke && cyc == 5) start = 1'b1;
      if (poke && cyc == 6) start = 1'b0;
    end
    check({name, "_latency"}, cyc, LAT);
    @(negedge clk);
    check({name, "_nwrites"}, wr_cnt - w0, NW);
    check({name, "_ctb"}, res_mem[0], e_ctb);
    check({name, "_cto"}, res_mem[1], e_cto);
`ifdef PSCAN_CROSS_EN
    check({name, "_cts"}, res_mem[2], e_cts);
`else
    check({name, "_cts_untouched"}, res_mem[2], 8'hA5);
`endif
    check({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    reset_n = 1'b0;
    start   = 1'b0;
    clr_res = 1'b0;
    load(8'h00, 8'h00, 8'h00);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 8'd0);
    check("rst_wdata", mem_wdata, 8'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    load(8'h00, 8'h00, 8'h00);
    run_scan("zeros", 8'd128, 8'd32, 8'd252, 1'b0);
    load(8'hFF, 8'hFF, 8'h20);
    run_scan("ones", 8'd0, 8'd0, 8'd0, 1'b0);
    load(8'h04, 8'h00, 8'h20);
    run_scan("single", 8'd1, 8'd1, 8'd1, 1'b0);
    load(8'h55, 8'h55, 8'hA8);
    run_scan("alt", 8'd64, 8'd32, 8'd126, 1'b0);

    // Reset ten bytes into the scan: no writes may follow and the block idles.
    load(8'h00, 8'h00, 8'h00);
    w0 = wr_cnt;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_we", mem_we, 1'b0);
    check("mid_rst_addr", mem_addr, 8'd0);
    check("mid_rst_wdata", mem_wdata, 8'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("mid_rst_nowrite", wr_cnt - w0, 0);
    check("mid_rst_idle_done", done, 1'b0);
    check("mid_rst_idle_busy", busy, 1'b0);

    load(8'h55, 8'h55, 8'hA8);
    run_scan("after_rst_poke", 8'd64, 8'd32, 8'd126, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'd0: address of the first string byte.
REQ-002 SHALL have parameter STR_LEN, default 32: string length in bytes, range 2..32.
REQ-003 SHALL have parameter PAT_ADDR, default 8'd32: address of the pattern byte; the pattern is in bits [7:3].
REQ-004 SHALL have parameter RES_ADDR, default 8'd33: results go to RES_ADDR, RES_ADDR+1 and RES_ADDR+2.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: request to begin a scan.
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE and DONE.
REQ-009 SHALL have port done, output, 1 bit: scan complete; high only in DONE.
REQ-010 SHALL have port mem_addr, output, 8 bits: data memory address.
REQ-011 SHALL have port mem_rdata, input, 8 bits: data memory read data, combinational from mem_addr.
REQ-012 SHALL have port mem_wdata, output, 8 bits: data memory write data.
REQ-013 SHALL have port mem_we, output, 1 bit: data memory write enable; memory writes on the clk edge.

Function
REQ-014 SHALL implement the states IDLE, LD_PAT, SCAN, WR_CTB, WR_CTO, WR_CTS and DONE.
REQ-015 SHALL, in IDLE or DONE, go to LD_PAT when start=1 is sampled; a start in DONE clears done and restarts.
REQ-016 SHALL ignore start while busy=1.
REQ-017 SHALL, in LD_PAT (1 cycle), drive mem_addr=PAT_ADDR, latch pattern=mem_rdata[7:3], and clear all counters and the previous-byte register.
REQ-018 SHALL, in SCAN (STR_LEN cycles), drive mem_addr=BASE_ADDR+idx for idx=0..STR_LEN-1 and evaluate byte b=mem_rdata in the same cycle.
REQ-019 SHALL, for each byte, increment ctb once per match of b[4:0], b[5:1], b[6:2] or b[7:3] with the pattern (0..4 per byte).
REQ-020 SHALL increment cto by 1 for each byte with at least one in-byte match.
REQ-021 SHALL, for idx>0, add to cts the matches of the four byte-crossing windows {p[3:0],b[7]}, {p[2:0],b[7:6]}, {p[1:0],b[7:5]} and {p[0],b[7:4]}, where p is the previous byte, in addition to that byte's in-byte matches.
REQ-022 SHALL make cts equal to the count over all 8*STR_LEN-4 windows of the MSB-first concatenated string (maximum 252).
REQ-023 SHALL keep ctb, cto and cts as 8-bit counters that never wrap for any STR_LEN of 32 or less.
REQ-024 SHALL, in WR_CTB, WR_CTO and WR_CTS (1 cycle each), assert mem_we with mem_addr = RES_ADDR+0/+1/+2 and mem_wdata = ctb/cto/cts.
REQ-025 SHALL then enter DONE, which holds until start.
REQ-026 SHALL hold mem_we=0 in every other state.
REQ-027 SHALL assert done on the 36th rising edge after the edge that samples start (1+STR_LEN+3 for STR_LEN=32).

Reset
REQ-028 SHALL, while reset_n=0, immediately force: state=IDLE, busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, and all counters, pattern, idx and previous byte to 0.
REQ-029 SHALL, on reset mid-scan or mid-write, perform no further writes and require a new start.

Configuration
REQ-030 SHALL, with PSCAN_CROSS_EN defined, implement the crossing windows and the WR_CTS state as specified above.
REQ-031 SHALL, without PSCAN_CROSS_EN, remove the cts logic and go WR_CTO -> DONE, so RES_ADDR+2 is never written and done arrives 1 cycle earlier.

Structure
REQ-032 SHALL take the state enum, default address constants and counter width from package pscan_pkg.
REQ-033 SHALL use one combinational sub-module, pscan_match, which takes the 5-bit pattern, current byte and previous byte and returns the in-byte match count (3 bits), an any-match flag and the crossing match count (3 bits).

Verification
REQ-034 SHALL verify: all 32 bytes 0x00, mem[32]=0x00 -> mem[33]=128, mem[34]=32, mem[35]=252; done 36 cycles after start.
REQ-035 SHALL verify: all bytes 0xFF, mem[32]=0x20 (pattern 00100) -> 0, 0, 0.
REQ-036 SHALL verify: byte0=0x04, others 0x00, pattern 00100 -> 1, 1, 1.
REQ-037 SHALL verify: all bytes 0x55, mem[32]=0xA8 (pattern 10101) -> 64, 32, 126.
REQ-038 SHALL verify: reset_n pulsed low 10 cycles into SCAN -> no mem_we, done=0; a following start gives correct results; a start pulsed while busy has no effect.
REQ-039 SHALL verify: built without PSCAN_CROSS_EN -> exactly 2 writes, mem[35] untouched, done at cycle 35.
